serial_twos_complementer: RTL and testbench

//   Bit-serial two's complement engine with parallel valid/ready load and unload.

---
 rtl/serial_twos_complementer.sv | 92 +++++++++
 tb/tb_serial_twos_complementer.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/serial_twos_complementer.sv
// rtl/serial_twos_complementer.sv - bit-serial two's complement negator with parallel load/unload
module serial_twos_complementer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_ovf,
  output logic             ser_valid,
  output logic             ser_bit,
  output logic             busy
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] sreg;
  logic [WIDTH-1:0] res;
  logic [CW-1:0]    count;
  logic             seen;
  logic             msb_in;
  logic             rdy;

  // Bits up to and including the first 1 pass through; later bits are inverted.
  assign ser_valid = (state == SHIFT);
  assign ser_bit   = ser_valid & (sreg[0] ^ seen);
  assign out_valid = (state == DONE);
  assign out_data  = res;
  assign out_ovf   = out_valid & msb_in & res[WIDTH-1];
  assign busy      = (state != IDLE);
  assign in_ready  = rdy;

  // Load / shift / unload sequencing; rdy is a flop so in_ready stays low until the first edge after reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      sreg   <= '0;
      res    <= '0;
      count  <= '0;
      seen   <= 1'b0;
      msb_in <= 1'b0;
      rdy    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          rdy <= 1'b1;
          if (rdy && in_valid) begin
            sreg   <= in_data;
            seen   <= 1'b0;
            count  <= '0;
            msb_in <= in_data[WIDTH-1];
            rdy    <= 1'b0;
            state  <= SHIFT;
          end
        end
        SHIFT: begin
          res  <= {ser_bit, res[WIDTH-1:1]};
          sreg <= sreg >> 1;
          seen <= seen | sreg[0];
          if (count == LAST) begin
            state <= DONE;
          end else begin
            count <= count + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state <= IDLE;
            rdy   <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          rdy   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_twos_complementer.sv
// tb/tb_serial_twos_complementer.sv - directed and randomized checks for serial_twos_complementer
module tb_serial_twos_complementer;

  localparam int W = 8;
  localparam int NRAND = 300;

  logic         clk;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic         out_ovf;
  logic         ser_valid;
  logic         ser_bit;
  logic         busy;

  int tests;
  int fails;

  typedef struct {
    logic [W-1:0] d;
    logic [W-1:0] e;
    logic         ovf;
  } vec_t;

  vec_t vecs[6];

  serial_twos_complementer #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ovf   (out_ovf),
    .ser_valid (ser_valid),
    .ser_bit   (ser_bit),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Accept one word, check the serial stream and result, hold out_ready low for 'hold' cycles, then unload.
  task automatic send_word(input logic [W-1:0] d, input logic [W-1:0] e, input logic ovf, input int hold);
    for (int k = 0; k < 20 && !in_ready; k++) @(negedge clk);
    check("in_ready before load", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1;
    in_data  = d;
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = ~d;
    check("in_ready after load", {31'd0, in_ready}, 32'd0);
    for (int i = 0; i < W; i++) begin
      check("ser_valid", {31'd0, ser_valid}, 32'd1);
      check("ser_bit", {31'd0, ser_bit}, {31'd0, e[i]});
      check("out_valid during shift", {31'd0, out_valid}, 32'd0);
      @(negedge clk);
    end
    check("out_valid latency", {31'd0, out_valid}, 32'd1);
    check("out_data", {24'd0, out_data}, {24'd0, e});
    check("out_ovf", {31'd0, out_ovf}, {31'd0, ovf});
    for (int h = 0; h < hold; h++) begin
      in_valid = h[0];
      in_data  = 8'hAA;
      @(negedge clk);
      check("bp out_valid", {31'd0, out_valid}, 32'd1);
      check("bp out_data", {24'd0, out_data}, {24'd0, e});
      check("bp in_ready", {31'd0, in_ready}, 32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("unload out_valid", {31'd0, out_valid}, 32'd0);
    check("unload busy", {31'd0, busy}, 32'd0);
    check("unload in_ready", {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    logic [W-1:0] q[$];
    logic [W-1:0] exp_d;
    int n_in;
    int n_out;
    int cyc;
    int seen_valid;

    tests     = 0;
    fails     = 0;
    reset     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;

    vecs[0] = '{8'h06, 8'hFA, 1'b0};
    vecs[1] = '{8'h00, 8'h00, 1'b0};
    vecs[2] = '{8'h80, 8'h80, 1'b1};
    vecs[3] = '{8'h01, 8'hFF, 1'b0};
    vecs[4] = '{8'hFF, 8'h01, 1'b0};
    vecs[5] = '{8'h7F, 8'h81, 1'b0};

    // Reset state
    @(negedge clk);
    @(negedge clk);
    check("rst in_ready", {31'd0, in_ready}, 32'd0);
    check("rst out_valid", {31'd0, out_valid}, 32'd0);
    check("rst out_data", {24'd0, out_data}, 32'd0);
    check("rst busy", {31'd0, busy}, 32'd0);
    check("rst ser_valid", {31'd0, ser_valid}, 32'd0);
    reset = 1'b1;
    #1;
    check("in_ready before first edge", {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    check("in_ready after release", {31'd0, in_ready}, 32'd1);

    // Directed vectors
    for (int v = 0; v < 6; v++) begin
      send_word(vecs[v].d, vecs[v].e, vecs[v].ovf, 0);
    end

    // Backpressure: 5 cycles with out_ready low, in_valid pulses ignored
    send_word(8'h13, 8'hED, 1'b0, 5);

    // Abort mid-shift with an asynchronous reset pulse
    in_valid = 1'b1;
    in_data  = 8'h5A;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("abort in shift", {31'd0, ser_valid}, 32'd1);
    #2;
    reset = 1'b0;
    #1;
    check("abort busy", {31'd0, busy}, 32'd0);
    check("abort ser_valid", {31'd0, ser_valid}, 32'd0);
    check("abort ser_bit", {31'd0, ser_bit}, 32'd0);
    check("abort in_ready", {31'd0, in_ready}, 32'd0);
    check("abort out_data", {24'd0, out_data}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    seen_valid = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (out_valid) seen_valid++;
    end
    check("abort no out_valid", seen_valid, 32'd0);
    send_word(8'h03, 8'hFD, 1'b0, 0);

    // Random stream with stalls on both sides
    n_in  = 0;
    n_out = 0;
    cyc   = 0;
    while (n_out < NRAND && cyc < 20000) begin
      @(negedge clk);
      cyc++;
      in_valid  = (n_in < NRAND) && ($urandom_range(0, 3) != 0);
      in_data   = W'($urandom);
      out_ready = ($urandom_range(0, 2) != 0);
      if (in_valid && in_ready) begin
        q.push_back(in_data);
        n_in++;
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          check("rand unexpected result", 32'd1, 32'd0);
        end else begin
          exp_d = q.pop_front();
          check("rand out_data", {24'd0, out_data}, {24'd0, W'(~exp_d + 1'b1)});
          check("rand out_ovf", {31'd0, out_ovf}, {31'd0, exp_d == 8'h80});
        end
        n_out++;
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check("rand result count", n_out, NRAND);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
